fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Sequencing controller for the two 3-way EX-stage operand muxes of the 5-stage pipelined CPU.
- Tracks destination tags of in-flight instructions through EX, MEM and WB in its own shadow pipeline.
- Drives the 2-bit operand-mux selects and detects load-use hazards.
- Stalls the front end and inserts bubbles. Counts stall cycles for the perf counter.

Parameters:
REG_AW, 5, register-index width
CNT_W, 16, stall counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
id_valid_i  in  1  ID stage holds a real instruction
id_rs_i  in  REG_AW  ID source register 1
id_rt_i  in  REG_AW  ID source register 2
id_uses_rt_i  in  1  ID instruction reads rt as an operand
id_rd_i  in  REG_AW  ID destination register (already resolved rd/rt)
id_regwrite_i  in  1  ID instruction writes the register file
id_memread_i  in  1  ID instruction is a load
flush_i  in  1  branch taken; kill the ID instruction this cycle
fwd_a_o  out  2  select for operand-A mux
fwd_b_o  out  2  select for operand-B mux
stall_o  out  1  hold PC and IF/ID; bubble into EX
stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Mux select encoding (fixed):
  - 00 = register-file value
  - 01 = EX/MEM ALU result
  - 10 = MEM/WB write-back value
  - 11 is never driven
- Reset (rst_i low, async):
  - All shadow stages have valid=0 and all tags=0.
  - fwd_a_o=00, fwd_b_o=00, stall_o=0, stall_cnt_o=0.
  - Reset mid-operation discards all in-flight tags. First cycle after release: no forwarding.
- Shadow pipeline: registers EX{valid,rs,rt,uses_rt,rd,regwrite,memread}, MEM{valid,rd,regwrite}, WB{valid,rd,regwrite}. Each clock:
  - WB <= MEM
  - MEM <= EX
  - EX <= ID fields if id_valid_i & !stall_o & !flush_i; otherwise EX.valid <= 0 (bubble)
- Forwarding (combinational from registered EX/MEM/WB only, no ID-input paths), for operand A on EX.rs:
  - 01 if MEM.valid & MEM.regwrite & MEM.rd!=0 & MEM.rd==EX.rs
  - else 10 if WB.valid & WB.regwrite & WB.rd!=0 & WB.rd==EX.rs
  - else 00
  - MEM has priority over WB when both match.
- Forwarding for operand B: same rules on EX.rt, gated by EX.uses_rt (else 00).
- EX.valid=0 forces both selects to 00.
- Register r0 is never forwarded.
- The register file is write-before-read. ID reading a register that WB writes in the same cycle needs no action.
- Load-use stall (combinational):
  - stall_o = id_valid_i & !flush_i & EX.valid & EX.memread & EX.rd!=0 & (EX.rd==id_rs_i | (id_uses_rt_i & EX.rd==id_rt_i)).
  - One stall cycle per hazard. The next cycle the load is in MEM and EX holds a bubble, so stall_o drops and the instruction proceeds with select 10 one cycle later.
  - This guarantees select 01 is never chosen for a load's address result.
- Simultaneous events: flush_i=1 overrides stall_o to 0 and inserts a bubble. A flush during a would-be stall kills the dependent instruction.
- stall_cnt_o: increments by 1 on each clock where stall_o=1. Saturates at all-ones, with no wrap.

Decomposition:
- Shared CPU package holds:
  - select-encoding constants (FWD_REG=00, FWD_EXMEM=01, FWD_MEMWB=10)
  - REG_AW
  - a stage-tag struct type {valid, rd, regwrite}
- One natural sub-module: fwd_sel_unit, the pure combinational comparator producing one 2-bit select from {src, uses, MEM tag, WB tag}. Instantiate it twice, once for A and once for B.

Test Plan:
- Reset: assert rst_i low mid-stream with valid tags loaded -> all outputs 0 immediately; after release, no forward until new instructions propagate.
- EX/MEM forward: issue add r3 (regwrite), then sub with rs=3 -> in the sub's EX cycle fwd_a_o=01.
- MEM/WB forward and priority:
  - add r3, nop, then use of r3 as rt (uses_rt=1) -> fwd_b_o=10.
  - add r3, add r3, use r3 -> fwd_a_o=01 (MEM wins).
- r0 and uses_rt gating:
  - writer rd=0 followed by reader rs=0 -> selects 00.
  - reader with rt match but id_uses_rt_i=0 -> fwd_b_o=00.
- Load-use: lw r5, then add rs=5 -> stall_o=1 for exactly 1 cycle; stall_cnt_o 0->1; add's EX cycle shows fwd_a_o=10.
- Flush vs stall and saturation:
  - lw r5, then dependent add with flush_i=1 -> stall_o=0, bubble, no forward.
  - With CNT_W=4, force 20 stall cycles -> stall_cnt_o holds 15.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
// fwd_hazard_ctrl_pkg: shared CPU types for operand forwarding and hazard control.
package fwd_hazard_ctrl_pkg;
  localparam int REG_AW = 5;
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } stage_tag_t;
endpackage

// File: rtl/fwd_sel_unit.sv
// fwd_sel_unit: picks one operand-mux select from the MEM and WB destination tags.
module fwd_sel_unit
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_uses,
  input  stage_tag_t        i_mem,
  input  stage_tag_t        i_wb,
  output logic [1:0]        o_sel
);
  logic w_mem_hit, w_wb_hit;
  assign w_mem_hit = i_uses & i_mem.valid & i_mem.regwrite & (i_mem.rd != '0) & (i_mem.rd == i_src);
  assign w_wb_hit  = i_uses & i_wb.valid & i_wb.regwrite & (i_wb.rd != '0) & (i_wb.rd == i_src);
  assign o_sel     = w_mem_hit ? FWD_EXMEM : w_wb_hit ? FWD_MEMWB : FWD_REG;
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: shadow EX/MEM/WB tag pipeline driving forwarding selects and load-use stalls.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  stage_tag_t        r_ex, r_mem, r_wb;
  logic [REG_AW-1:0] r_ex_rs, r_ex_rt;
  logic              r_ex_uses_rt, r_ex_memread;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_accept;
  assign stall_o = id_valid_i & ~flush_i & r_ex.valid & r_ex_memread & (r_ex.rd != '0) &
                   ((r_ex.rd == id_rs_i) | (id_uses_rt_i & (r_ex.rd == id_rt_i)));
  assign w_accept    = id_valid_i & ~stall_o & ~flush_i;
  assign stall_cnt_o = r_cnt;
  // EX fields are loaded unconditionally; valid alone marks a bubble
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ex         <= '0;
      r_mem        <= '0;
      r_wb         <= '0;
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_uses_rt <= 1'b0;
      r_ex_memread <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_wb         <= r_mem;
      r_mem        <= r_ex;
      r_ex         <= '{valid: w_accept, rd: id_rd_i, regwrite: id_regwrite_i};
      r_ex_rs      <= id_rs_i;
      r_ex_rt      <= id_rt_i;
      r_ex_uses_rt <= id_uses_rt_i;
      r_ex_memread <= id_memread_i;
      if (stall_o && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end
  fwd_sel_unit u_sel_a (
    .i_src (r_ex_rs),
    .i_uses(r_ex.valid),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (fwd_a_o)
  );
  fwd_sel_unit u_sel_b (
    .i_src (r_ex_rt),
    .i_uses(r_ex.valid & r_ex_uses_rt),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (fwd_b_o)
  );
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: table-driven checks of forwarding selects, load-use stalls and stall counting.
module tb_fwd_hazard_ctrl;
  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       ut;
    logic [4:0] rd;
    logic       rw, mr, fl;
    logic [1:0] ea, eb;
    logic       es;
    logic [15:0] ec;
  } vec_t;

  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic        id_valid_i = 1'b0, id_uses_rt_i = 1'b0, id_regwrite_i = 1'b0, id_memread_i = 1'b0, flush_i = 1'b0;
  logic [4:0]  id_rs_i = '0, id_rt_i = '0, id_rd_i = '0;
  logic [1:0]  fwd_a_o, fwd_b_o, fwd_a4, fwd_b4;
  logic        stall_o, stall4;
  logic [15:0] stall_cnt_o;
  logic [3:0]  cnt4;
  int          n_chk = 0, n_fail = 0;
  vec_t        tbl[$];

  always #5 clk_i = ~clk_i;

  fwd_hazard_ctrl #(.CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_uses_rt_i(id_uses_rt_i), .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .flush_i(flush_i), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );
  fwd_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_uses_rt_i(id_uses_rt_i), .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .flush_i(flush_i), .fwd_a_o(fwd_a4), .fwd_b_o(fwd_b4),
    .stall_o(stall4), .stall_cnt_o(cnt4)
  );

  function automatic vec_t mk(int v, int rs, int rt, int ut, int rd, int rw, int mr, int fl,
                              int ea, int eb, int es, int ec);
    vec_t r;
    r.v = 1'(v); r.rs = 5'(rs); r.rt = 5'(rt); r.ut = 1'(ut); r.rd = 5'(rd);
    r.rw = 1'(rw); r.mr = 1'(mr); r.fl = 1'(fl);
    r.ea = 2'(ea); r.eb = 2'(eb); r.es = 1'(es); r.ec = 16'(ec);
    return r;
  endfunction

  function automatic vec_t nop(int ea, int eb, int es, int ec);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, ea, eb, es, ec);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    id_valid_i = t.v; id_rs_i = t.rs; id_rt_i = t.rt; id_uses_rt_i = t.ut;
    id_rd_i = t.rd; id_regwrite_i = t.rw; id_memread_i = t.mr; flush_i = t.fl;
  endtask

  initial begin
    int n_st;
    // row: v rs rt ut rd rw mr fl | exp fwd_a fwd_b stall cnt (outputs seen while the row sits in ID)
    tbl.push_back(mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0));   // add r3
    tbl.push_back(mk(1, 3, 4, 1, 6, 1, 0, 0, 0, 0, 0, 0));   // sub rs=r3
    tbl.push_back(nop(1, 0, 0, 0));                          // sub in EX, add in MEM
    tbl.push_back(mk(1, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0));   // add r3
    tbl.push_back(nop(0, 0, 0, 0));
    tbl.push_back(mk(1, 7, 3, 1, 8, 1, 0, 0, 0, 0, 0, 0));   // or rt=r3
    tbl.push_back(nop(0, 2, 0, 0));                          // r3 writer in WB
    tbl.push_back(mk(1, 1, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0));   // add r9
    tbl.push_back(mk(1, 1, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0));   // add r9
    tbl.push_back(mk(1, 9, 9, 0, 10, 1, 0, 0, 0, 0, 0, 0));  // rs=rt=r9, rt unused
    tbl.push_back(nop(1, 0, 0, 0));                          // MEM wins, B gated
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));   // writer r0
    tbl.push_back(mk(1, 0, 0, 1, 11, 1, 0, 0, 0, 0, 0, 0));  // reader r0
    tbl.push_back(nop(0, 0, 0, 0));                          // r0 not forwarded
    tbl.push_back(mk(1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0));   // lw r5
    tbl.push_back(mk(1, 5, 6, 1, 12, 1, 0, 0, 0, 0, 1, 0));  // add rs=r5 stalls
    tbl.push_back(mk(1, 5, 6, 1, 12, 1, 0, 0, 0, 0, 0, 1));  // held, proceeds
    tbl.push_back(nop(2, 0, 0, 1));                          // load value from WB
    tbl.push_back(mk(1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1));   // lw r5
    tbl.push_back(mk(1, 5, 6, 1, 12, 1, 0, 1, 0, 0, 0, 1));  // dependent add flushed
    tbl.push_back(nop(0, 0, 0, 1));                          // bubble in EX
    tbl.push_back(mk(1, 2, 2, 0, 7, 1, 1, 0, 0, 0, 0, 1));   // lw r7
    tbl.push_back(mk(1, 1, 7, 1, 13, 1, 0, 0, 0, 0, 1, 1));  // rt=r7 stalls
    tbl.push_back(mk(1, 1, 7, 1, 13, 1, 0, 0, 0, 0, 0, 2));
    tbl.push_back(nop(0, 2, 0, 2));
    tbl.push_back(mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 2));   // add r3
    tbl.push_back(mk(1, 3, 4, 1, 6, 1, 0, 0, 0, 0, 0, 2));   // sub rs=r3
    #3;
    chk("reset fwd_a", int'(fwd_a_o), 0);
    chk("reset fwd_b", int'(fwd_b_o), 0);
    chk("reset stall", int'(stall_o), 0);
    chk("reset cnt", int'(stall_cnt_o), 0);
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i) #1;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d fwd_a", i), int'(fwd_a_o), int'(tbl[i].ea));
      chk($sformatf("row%0d fwd_b", i), int'(fwd_b_o), int'(tbl[i].eb));
      chk($sformatf("row%0d stall", i), int'(stall_o), int'(tbl[i].es));
      chk($sformatf("row%0d cnt", i), int'(stall_cnt_o), int'(tbl[i].ec));
      @(posedge clk_i) #1;
    end
    drive(nop(0, 0, 0, 0));
    #1;
    chk("pre-reset fwd_a", int'(fwd_a_o), 1);
    rst_i = 1'b0;
    #1;
    chk("async reset fwd_a", int'(fwd_a_o), 0);
    chk("async reset stall", int'(stall_o), 0);
    chk("async reset cnt", int'(stall_cnt_o), 0);
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i) #1;
    chk("post-reset fwd_a", int'(fwd_a_o), 0);
    drive(mk(1, 3, 3, 1, 6, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk_i) #1;
    drive(nop(0, 0, 0, 0));
    #1;
    chk("post-reset no fwd a", int'(fwd_a_o), 0);
    chk("post-reset no fwd b", int'(fwd_b_o), 0);
    // lw r5,(r5) held in ID: every second cycle it stalls on itself
    n_st = 0;
    for (int i = 0; i < 40; i++) begin
      drive(mk(1, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0));
      #1;
      chk($sformatf("sat%0d stall", i), int'(stall_o), i % 2);
      chk($sformatf("sat%0d stall4", i), int'(stall4), i % 2);
      if (i % 2 == 1) n_st++;
      @(posedge clk_i) #1;
    end
    drive(nop(0, 0, 0, 0));
    #1;
    chk("cnt16 after stalls", int'(stall_cnt_o), n_st);
    chk("cnt4 saturated", int'(cnt4), (n_st > 15) ? 15 : n_st);
    chk("dut4 fwd_a idle", int'(fwd_a4), 0);
    chk("dut4 fwd_b idle", int'(fwd_b4), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
